// File: rtl/stage2_id_branch.sv
// stage2_id_branch: decode-stage front end with branch resolution.
// Latches {inst, pc} from IF under valid/allow_in, reads rj/rd from
// the regfile, resolves jirl/b/bl/beq/bne/blt/bge/bltu/bgeu and drives
// br_bus {cancel, taken, target} back to IF.
// Ports: clk, reset (sync, active-high); fs_to_ds_valid/bus in;
// ds_allow_in out; br_bus out; rf_raddr1/2 out, rf_rdata1/2 in;
// ds_stall, es_allow_in in; ds_to_es_valid/bus out.
module stage2_id_branch (
  input  logic         clk,
  input  logic         reset,
  input  logic         fs_to_ds_valid,
  input  logic [63:0]  fs_to_ds_bus,
  output logic         ds_allow_in,
  output logic [33:0]  br_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic         ds_stall,
  input  logic         es_allow_in,
  output logic         ds_to_es_valid,
  output logic [127:0] ds_to_es_bus
);

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  logic        ds_valid;
  logic [31:0] ds_inst;
  logic [31:0] ds_pc;

  logic        ds_ready_go;
  logic        cond;
  logic        br_taken;
  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic [31:0] target;
  logic [5:0]  op;
  logic [15:0] offs16;
  logic [25:0] offs26;
  logic [31:0] imm16;
  logic [31:0] imm26;
  logic        eq;
  logic        lt_s;
  logic        lt_u;

  assign ds_ready_go    = !ds_stall;
  assign ds_allow_in    = !ds_valid
                        || (ds_ready_go && es_allow_in);
  assign ds_to_es_valid = ds_valid && ds_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_inst  <= 32'h0;
      ds_pc    <= 32'h0;
    end else if (ds_allow_in) begin
      ds_valid <= fs_to_ds_valid && !br_taken_cancel;
      if (fs_to_ds_valid) begin
        ds_inst <= fs_to_ds_bus[63:32];
        ds_pc   <= fs_to_ds_bus[31:0];
      end
    end
  end

  assign op     = ds_inst[31:26];
  assign offs16 = ds_inst[25:10];
  assign offs26 = {ds_inst[9:0], ds_inst[25:10]};
  assign imm16  = {{14{offs16[15]}}, offs16, 2'b00};
  assign imm26  = {{4{offs26[25]}}, offs26, 2'b00};

  assign rf_raddr1 = ds_inst[9:5];
  assign rf_raddr2 = ds_inst[4:0];

  assign eq   = rf_rdata1 == rf_rdata2;
  assign lt_s = $signed(rf_rdata1) < $signed(rf_rdata2);
  assign lt_u = rf_rdata1 < rf_rdata2;

  always_comb begin
    cond   = 1'b0;
    target = ds_pc + imm16;
    unique case (1'b1)
      (op == OP_JIRL): begin
        cond   = 1'b1;
        target = rf_rdata1 + imm16;
      end
      (op == OP_B),
      (op == OP_BL): begin
        cond   = 1'b1;
        target = ds_pc + imm26;
      end
      (op == OP_BEQ):  cond = eq;
      (op == OP_BNE):  cond = !eq;
      (op == OP_BLT):  cond = lt_s;
      (op == OP_BGE):  cond = !lt_s;
      (op == OP_BLTU): cond = lt_u;
      (op == OP_BGEU): cond = !lt_u;
      default:         cond = 1'b0;
    endcase
  end

  // Reset masks the redirect in the very cycle it is sampled, so IF
  // never sees a branch from a stage that is being flushed.
  assign br_taken = !reset && ds_valid
                  && ds_ready_go && cond;
  assign br_taken_cancel = br_taken && es_allow_in;
  assign br_target = br_taken ? target : 32'h0;
  assign br_bus = {br_taken_cancel, br_taken, br_target};

  assign ds_to_es_bus = {ds_inst, ds_pc,
                         rf_rdata1, rf_rdata2};

endmodule

// File: tb/tb_stage2_id_branch.sv
// Testbench for stage2_id_branch: scoreboard of IF->EX payloads
// plus per-scenario checks of br_bus and the handshake.
module tb_stage2_id_branch;

  logic         clk = 1'b0;
  logic         reset;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_allow_in;
  logic [33:0]  br_bus;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic         ds_stall;
  logic         es_allow_in;
  logic         ds_to_es_valid;
  logic [127:0] ds_to_es_bus;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0280_0000;

  stage2_id_branch dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allow_in    (ds_allow_in),
    .br_bus         (br_bus),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .ds_stall       (ds_stall),
    .es_allow_in    (es_allow_in),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc16(input logic [5:0] op,
    input logic [15:0] off, input logic [4:0] rj,
    input logic [4:0] rd);
    return {op, off, rj, rd};
  endfunction

  function automatic logic [31:0] enc26(input logic [5:0] op,
    input logic [25:0] off);
    return {op, off[15:0], off[25:16]};
  endfunction

  // Advance one cycle; at the negedge, pop the scoreboard for any
  // instruction transferring to EX at the coming edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (!reset && ds_to_es_valid && es_allow_in) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got %h required none",
                 ds_to_es_bus[127:64]);
      end else begin
        e = exp_q.pop_front();
        if (ds_to_es_bus[127:64] !== e) begin
          n_errors++;
          $display("FAIL sb_payload: got %h required %h",
                   ds_to_es_bus[127:64], e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] inst,
    input logic [31:0] pc, input logic keep);
    fs_to_ds_valid = v;
    fs_to_ds_bus   = {inst, pc};
    if (keep) exp_q.push_back({inst, pc});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ds_to_es_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_valid: got %b required 0", ds_to_es_valid);
    end
    n_checks++;
    if (ds_allow_in !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_allow: got %b required 1", ds_allow_in);
    end
    n_checks++;
    if (br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL rst_br: got %h required 0", br_bus);
    end
    n_checks++;
    if (ds_to_es_bus[127:64] !== 64'h0) begin
      n_errors++;
      $display("FAIL rst_regs: got %h required 0",
               ds_to_es_bus[127:64]);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    fetch(1'b1, NOP, 32'h1C00_0000, 1'b1);
    tick();
    fetch(1'b1, NOP, 32'h1C00_0004, 1'b1);
    #1;
    n_checks++;
    if (ds_to_es_valid !== 1'b1 ||
        ds_to_es_bus[95:64] !== 32'h1C00_0000) begin
      n_errors++;
      $display("FAIL stream_0: got v=%b pc=%h required 1 1c000000",
               ds_to_es_valid, ds_to_es_bus[95:64]);
    end
    n_checks++;
    if (br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL stream_br: got %h required 0", br_bus);
    end
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (ds_to_es_valid !== 1'b1 ||
        ds_to_es_bus[95:64] !== 32'h1C00_0004) begin
      n_errors++;
      $display("FAIL stream_1: got v=%b pc=%h required 1 1c000004",
               ds_to_es_valid, ds_to_es_bus[95:64]);
    end
    tick();
    n_checks++;
    if (ds_to_es_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_idle: got %b required 0", ds_to_es_valid);
    end
  endtask

  task automatic test_beq_taken();
    fetch(1'b1, enc16(6'h16, 16'h0004, 5'd1, 5'd2),
          32'h1C00_0010, 1'b1);
    tick();
    rf_rdata1 = 32'd5;
    rf_rdata2 = 32'd5;
    fetch(1'b1, NOP, 32'h1C00_0014, 1'b0);
    #1;
    n_checks++;
    if (br_bus !== 34'h3_1C00_0020) begin
      n_errors++;
      $display("FAIL beq_br: got %h required 31c000020", br_bus);
    end
    n_checks++;
    if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
      n_errors++;
      $display("FAIL beq_raddr: got %0d/%0d required 1/2",
               rf_raddr1, rf_raddr2);
    end
    n_checks++;
    if (ds_to_es_bus[63:0] !== 64'h5_0000_0005) begin
      n_errors++;
      $display("FAIL beq_opnd: got %h required 500000005",
               ds_to_es_bus[63:0]);
    end
    tick();
    n_checks++;
    if (ds_to_es_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL beq_drop: got %b required 0", ds_to_es_valid);
    end
    fetch(1'b1, NOP, 32'h1C00_0020, 1'b1);
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (ds_to_es_bus[95:64] !== 32'h1C00_0020) begin
      n_errors++;
      $display("FAIL beq_tgt: got %h required 1c000020",
               ds_to_es_bus[95:64]);
    end
    tick();
  endtask

  task automatic test_bne_not_taken();
    fetch(1'b1, enc16(6'h17, 16'h0010, 5'd3, 5'd4),
          32'h1C00_0100, 1'b1);
    tick();
    rf_rdata1 = 32'd7;
    rf_rdata2 = 32'd7;
    fetch(1'b1, NOP, 32'h1C00_0104, 1'b1);
    #1;
    n_checks++;
    if (br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL bne_br: got %h required 0", br_bus);
    end
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (ds_to_es_valid !== 1'b1 ||
        ds_to_es_bus[95:64] !== 32'h1C00_0104) begin
      n_errors++;
      $display("FAIL bne_seq: got v=%b pc=%h required 1 1c000104",
               ds_to_es_valid, ds_to_es_bus[95:64]);
    end
    tick();
  endtask

  task automatic test_signed_unsigned();
    fetch(1'b1, enc16(6'h1a, 16'h0008, 5'd1, 5'd2),
          32'h1C00_0200, 1'b1);
    tick();
    rf_rdata1 = 32'hFFFF_FFFF;
    rf_rdata2 = 32'd1;
    fetch(1'b1, enc16(6'h18, 16'h0008, 5'd1, 5'd2),
          32'h1C00_0204, 1'b1);
    #1;
    n_checks++;
    if (br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL bltu_br: got %h required 0", br_bus);
    end
    tick();
    fetch(1'b1, NOP, 32'h1C00_0208, 1'b0);
    #1;
    n_checks++;
    if (br_bus !== 34'h3_1C00_0224) begin
      n_errors++;
      $display("FAIL blt_br: got %h required 31c000224", br_bus);
    end
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    n_checks++;
    if (ds_to_es_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL blt_drop: got %b required 0", ds_to_es_valid);
    end
  endtask

  task automatic test_jumps();
    fetch(1'b1, enc16(6'h13, 16'hFFFF, 5'd5, 5'd6),
          32'h1C00_0300, 1'b1);
    tick();
    rf_rdata1 = 32'h1C00_1000;
    rf_rdata2 = 32'h0;
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (br_bus !== 34'h3_1C00_0FFC) begin
      n_errors++;
      $display("FAIL jirl_br: got %h required 31c000ffc", br_bus);
    end
    tick();
    fetch(1'b1, enc26(6'h14, 26'h3FF_FFFF), 32'h0, 1'b1);
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (br_bus !== 34'h3_FFFF_FFFC) begin
      n_errors++;
      $display("FAIL b_wrap: got %h required 3fffffffc", br_bus);
    end
    tick();
    fetch(1'b1, enc26(6'h15, 26'h000_0001),
          32'h1C00_0400, 1'b1);
    tick();
    fetch(1'b0, NOP, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (br_bus !== 34'h3_1C00_0404) begin
      n_errors++;
      $display("FAIL bl_br: got %h required 31c000404", br_bus);
    end
    tick();
  endtask

  task automatic test_cond_table();
    logic [5:0]  t_op[11] = '{6'h16, 6'h16, 6'h17, 6'h18, 6'h19,
      6'h19, 6'h1a, 6'h1b, 6'h1b, 6'h18, 6'h00};
    logic [31:0] t_a[11] = '{32'd5, 32'd5, 32'd1, 32'h8000_0000,
      32'h8000_0000, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd2,
      32'd4};
    logic [31:0] t_b[11] = '{32'd5, 32'd6, 32'd2, 32'd0, 32'd0,
      32'd3, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd2, 32'd4};
    logic        t_tk[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] pc;
    logic [33:0] exp_br;
    for (int i = 0; i < 11; i++) begin
      pc = 32'h1C00_1000 + 32'(i) * 32'h40;
      fetch(1'b1, enc16(t_op[i], 16'hFFFE, 5'd7, 5'd8), pc, 1'b1);
      tick();
      rf_rdata1 = t_a[i];
      rf_rdata2 = t_b[i];
      fetch(1'b0, NOP, 32'h0, 1'b0);
      #1;
      exp_br = t_tk[i] ? {2'b11, pc - 32'd8} : 34'h0;
      n_checks++;
      if (br_bus !== exp_br) begin
        n_errors++;
        $display("FAIL cond_%0d: got %h required %h",
                 i, br_bus, exp_br);
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    fetch(1'b1, enc16(6'h16, 16'h0004, 5'd1, 5'd2),
          32'h1C00_0500, 1'b1);
    tick();
    rf_rdata1 = 32'd3;
    rf_rdata2 = 32'd3;
    ds_stall  = 1'b1;
    fetch(1'b1, NOP, 32'h1C00_0504, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (br_bus !== 34'h0 || ds_allow_in !== 1'b0 ||
          ds_to_es_valid !== 1'b0 ||
          ds_to_es_bus[95:64] !== 32'h1C00_0500) begin
        n_errors++;
        $display("FAIL stall_%0d: got br=%h al=%b v=%b pc=%h required 0 0 0 1c000500",
                 c, br_bus, ds_allow_in, ds_to_es_valid,
                 ds_to_es_bus[95:64]);
      end
      tick();
    end
    ds_stall    = 1'b0;
    es_allow_in = 1'b0;
    #1;
    n_checks++;
    if (br_bus !== 34'h1_1C00_0510 || ds_allow_in !== 1'b0) begin
      n_errors++;
      $display("FAIL es_block: got br=%h al=%b required 11c000510 0",
               br_bus, ds_allow_in);
    end
    tick();
    n_checks++;
    if (ds_to_es_bus[95:64] !== 32'h1C00_0500) begin
      n_errors++;
      $display("FAIL es_hold: got %h required 1c000500",
               ds_to_es_bus[95:64]);
    end
    es_allow_in = 1'b1;
    #1;
    n_checks++;
    if (br_bus !== 34'h3_1C00_0510 || ds_allow_in !== 1'b1) begin
      n_errors++;
      $display("FAIL release: got br=%h al=%b required 31c000510 1",
               br_bus, ds_allow_in);
    end
    tick();
    n_checks++;
    if (br_bus !== 34'h0 || ds_to_es_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL once: got br=%h v=%b required 0 0",
               br_bus, ds_to_es_valid);
    end
    fetch(1'b0, NOP, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    fetch(1'b1, enc16(6'h16, 16'h0004, 5'd1, 5'd2),
          32'h1C00_0600, 1'b0);
    tick();
    rf_rdata1 = 32'd9;
    rf_rdata2 = 32'd9;
    fetch(1'b1, NOP, 32'h1C00_0604, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL rstmid_br: got %h required 0", br_bus);
    end
    tick();
    n_checks++;
    if (ds_to_es_valid !== 1'b0 ||
        ds_to_es_bus[127:64] !== 64'h0 || br_bus !== 34'h0) begin
      n_errors++;
      $display("FAIL rstmid_regs: got v=%b r=%h br=%h required 0 0 0",
               ds_to_es_valid, ds_to_es_bus[127:64], br_bus);
    end
    reset = 1'b0;
    fetch(1'b0, NOP, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = 64'h0;
    rf_rdata1      = 32'h0;
    rf_rdata2      = 32'h0;
    ds_stall       = 1'b0;
    es_allow_in    = 1'b1;
    test_reset();
    test_stream();
    test_beq_taken();
    test_bne_not_taken();
    test_signed_unsigned();
    test_jumps();
    test_cond_table();
    test_stall_hold();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stage2_id_branch.md
# stage2_id_branch

Decode-stage front end of the 5-stage LoongArch pipeline; the consumer of the fetch stage's `fs_to_ds_bus`/`fs_to_ds_valid` and the producer of its `br_bus`. It latches each fetched {inst, pc} under the valid/allow_in handshake and reads rj/rd from the register file. It resolves the nine control-transfer instructions in ID and drives the redirect/cancel bus back to IF. The latched instruction and its operands are forwarded to EX.

## Interface
- WIDTH_BR_BUS, 34, `{br_taken_cancel, br_taken, br_target[31:0]}`
- WIDTH_FS_TO_DS_BUS, 64, `{inst[31:0], pc[31:0]}`
- WIDTH_DS_TO_ES_BUS, 128, `{inst[31:0], pc[31:0], rj_value[31:0], rd_value[31:0]}`
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fs_to_ds_valid  in  1  IF holds a valid instruction
- fs_to_ds_bus  in  64  {inst, pc} from IF
- ds_allow_in  out  1  ID can accept from IF this cycle
- br_bus  out  34  redirect to IF
- rf_raddr1  out  5  = inst[9:5] (rj)
- rf_raddr2  out  5  = inst[4:0] (rd)
- rf_rdata1  in  32  asynchronous regfile read data, port 1
- rf_rdata2  in  32  asynchronous regfile read data, port 2
- ds_stall  in  1  hazard stall from the later-stage hazard logic
- es_allow_in  in  1  EX can accept
- ds_to_es_valid  out  1  ID presents a valid instruction to EX
- ds_to_es_bus  out  128  payload to EX

## Operation
- Registers: `ds_valid`, `ds_inst`, `ds_pc`. All reset to 0.
- `ds_ready_go = !ds_stall`.
- `ds_allow_in = !ds_valid || (ds_ready_go && es_allow_in)`.
- `ds_to_es_valid = ds_valid && ds_ready_go`.
- On `ds_allow_in`:
  - `ds_valid <= fs_to_ds_valid && !br_taken_cancel`.
  - If `fs_to_ds_valid`, then `{ds_inst, ds_pc} <= fs_to_ds_bus`.
- Otherwise all three registers hold.
- Decode on `op = ds_inst[31:26]`:
  - jirl 010011, b 010100, bl 010101
  - beq 010110, bne 010111
  - blt 011000, bge 011001 (signed compare)
  - bltu 011010, bgeu 011011 (unsigned compare)
- Offsets:
  - `offs16 = ds_inst[25:10]`
  - `offs26 = {ds_inst[9:0], ds_inst[25:10]}`
  - Each offset is shifted left 2 and sign-extended to 32 bits.
- Targets, computed modulo 2^32 with wrap-around allowed:
  - Conditional branches: `pc + sext(offs16<<2)`.
  - b/bl: `pc + sext(offs26<<2)`.
  - jirl: `rf_rdata1 + sext(offs16<<2)`.
- Condition: compare `rf_rdata1` (rj) against `rf_rdata2` (rd). b, bl and jirl are always taken.
- `br_taken = ds_valid && ds_ready_go && cond`.
- `br_taken_cancel = br_taken && es_allow_in`.
- `br_target` is the computed target whenever `br_taken`, else 0.
- Every non-branch opcode gives `br_taken = 0`.
- `ds_to_es_bus = {ds_inst, ds_pc, rf_rdata1, rf_rdata2}`.
- Link write (bl → r1, jirl → rd, value pc+4) is done downstream, not in this block.

## Timing
- Acceptance latency: an instruction accepted at edge N is visible on `ds_to_es_bus` and drives `br_bus` in cycle N+1.
- `br_bus`, `ds_allow_in` and `ds_to_es_valid` are combinational from registers and inputs. There is no registered redirect.
- Taken branch leaves ID (`br_taken_cancel = 1`, so `ds_allow_in = 1`):
  - The same edge loads `br_target` into IF's fetch_pc.
  - The sequential instruction IF presents that cycle is dropped (`ds_valid <= 0`).
  - The target instruction arrives in ID one cycle later.
- Taken branch with `es_allow_in = 0`:
  - `br_taken = 1`, `br_taken_cancel = 0`, `ds_allow_in = 0`.
  - Branch and IF contents hold; no redirect takes effect until EX accepts.
- `ds_stall = 1`:
  - `br_taken = 0`, because operands may be stale.
  - ID holds and `ds_to_es_valid = 0`.
  - Branch resolves in the first unstalled cycle.
- `ds_valid = 0`: `br_bus` is all-zero and `ds_allow_in = 1`.
- Reset asserted mid-operation:
  - Next edge: `ds_valid = 0`, `ds_inst = 0`, `ds_pc = 0`.
  - `br_bus` reads 0 in the same cycle reset is sampled and after.

## Test plan
- Reset, then IF streams pc 0x1C000000 and 0x1C000004 with non-branch inst 0x02800000 → `ds_to_es_valid` goes high one cycle after each accept, `ds_pc` matches, `br_bus = 0`.
- beq with pc = 0x1C000010, offs16 = 0x0004, rf_rdata1 = rf_rdata2 = 5, es_allow_in = 1 → `br_bus = {1, 1, 0x1C000020}`; next ds_valid = 0 even though fs_to_ds_valid = 1.
- bne with equal operands (7, 7) → `br_taken = 0`; next sequential instruction is accepted normally.
- bltu with rj = 0xFFFFFFFF, rd = 1 → not taken; blt with the same operands → taken, since signed -1 < 1.
- jirl with rj = 0x1C001000, offs16 = 0xFFFF → target 0x1C000FFC. b at pc 0x00000000 with offs26 = 0x3FFFFFF → target 0xFFFFFFFC (wraps).
- Taken beq with ds_stall = 1 for 2 cycles, then es_allow_in = 0 for 1 cycle:
  - While stalled: `br_taken = 0`, ds_allow_in = 0, ds_to_es_valid = 0, ID holds.
  - While es_allow_in = 0: `br_taken = 1`, `br_taken_cancel = 0`, ds_allow_in = 0, ID holds.
  - Fourth cycle: cancel = 1 and the redirect occurs exactly once.
